mcsr_file: RTL
==============

MCSR_FILE -- requirements
Module: mcsr_file

Interface
REQ-001 SHALL have parameter HART_ID, default 0, value returned by mhartid (0xF14).
REQ-002 SHALL have parameter MISA_VAL, default 32'h4000_0100 (RV32I), value returned by misa (0x301).
REQ-003 SHALL have parameter MTVEC_RST, default 32'h0000_0000, reset value of mtvec.
REQ-004 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-high.
REQ-005 SHALL have: csr_req_i in 1 access strobe; csr_op_i in 2 (01 RW, 10 RS, 11 RC, 00 none); csr_addr_i in 12; csr_wdata_i in 32.
REQ-006 SHALL have: csr_rdata_o out 32 old CSR value; csr_illegal_o out 1 access rejected.
REQ-007 SHALL have: instr_ret_i in 1 instruction retired; trap_i in 1; trap_cause_i in 32; trap_pc_i in 32; trap_val_i in 32; mret_i in 1.
REQ-008 SHALL have: irq_sw_i, irq_tim_i, irq_ext_i in 1 each, level interrupt sources.
REQ-009 SHALL have: trap_vec_o out 32 trap target; mepc_o out 32; irq_pending_o out 1.

Function
REQ-010 SHALL return csr_rdata_o combinationally in the request cycle; write takes effect at the next clk_i edge.
REQ-011 SHALL compute new value: RW = wdata; RS = old | wdata; RC = old & ~wdata; op 00 = no write.
REQ-012 SHALL map: misa 0x301, mvendorid/marchid/mimpid 0xF11-0xF13 (read 0), mhartid 0xF14, mstatus 0x300, mie 0x304, mtvec 0x305, mcountinhibit 0x320, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
REQ-013 SHALL assert csr_illegal_o for an unmapped address, or a write op when csr_addr_i[11:10]=11; illegal access changes no state, rdata 0.
REQ-014 SHALL treat misa and mip writes as ignored, not illegal.
REQ-015 mstatus SHALL implement MIE bit 3, MPIE bit 7; MPP [12:11] reads 11; other bits read 0.
REQ-016 mie SHALL implement bits 3, 7, 11 only; mcountinhibit bits 0, 2 only.
REQ-017 mtvec[1:0] SHALL be mode (00 direct, 01 vectored); write with mode 1x SHALL leave mode unchanged, base updated.
REQ-018 mepc[1:0] SHALL always read 0.
REQ-019 mip bits 3/7/11 SHALL be irq_sw_i/irq_tim_i/irq_ext_i registered once (1-cycle latency).
REQ-020 irq_pending_o SHALL equal mstatus.MIE & |(mip & mie), combinational from registers.
REQ-021 mcycle (64-bit) SHALL increment every cycle unless mcountinhibit[0]; minstret SHALL increment on instr_ret_i unless mcountinhibit[2]; both wrap 2^64-1 -> 0.
REQ-022 A CSR write to either half of a counter SHALL suppress that counter's increment in that cycle; the other half holds.
REQ-023 trap_i SHALL load mepc <= trap_pc_i & ~3, mcause <= trap_cause_i, mtval <= trap_val_i, MPIE <= MIE, MIE <= 0.
REQ-024 mret_i SHALL load MIE <= MPIE, MPIE <= 1.
REQ-025 Priority SHALL be trap_i > mret_i > CSR write; a CSR write in a trap_i or mret_i cycle SHALL be discarded, not flagged illegal.
REQ-026 trap_vec_o SHALL be {base,00}, or {base,00} + 4*trap_cause_i[4:0] when mode 01 and trap_cause_i[31]=1.
REQ-027 mepc_o SHALL present mepc continuously.

Reset
REQ-028 rst_i SHALL clear all registers to 0 except mtvec = MTVEC_RST; outputs follow from register values.
REQ-029 Reset mid-access SHALL discard the pending write.

Structure
REQ-030 Package mcsr_pkg SHALL hold CSR address constants, op encodings, mstatus/mip bit positions.
REQ-031 Sub-module mcsr_counter64 (64-bit counter, inhibit, per-half write) SHALL be instantiated for mcycle and minstret.

Verification
REQ-032 Reset, read 0x305 -> MTVEC_RST; read 0xF14 -> HART_ID; mcycle counts 0,1,2 over successive cycles.
REQ-033 RS 0x300 wdata 8 -> rdata 0x1800, then rdata 0x1808; RC 0x300 wdata 8 -> rdata 0x1808, then rdata 0x1800.
REQ-034 RW 0xF11, or RW 0x7C0 -> csr_illegal_o=1, no state change.
REQ-035 MIE=1, mtvec=0x1001, trap_i with cause 0x8000_0007, pc 0x206 -> trap_vec_o 0x101C, mepc 0x204, MIE=0, MPIE=1; mret_i -> MIE=1.
REQ-036 RW 0xB00 = 0xFFFF_FFFF, 0xB80 = 0xFFFF_FFFF -> next cycle wraps to 0; RW 0xB00 with instr_ret_i on minstret same cycle -> written value, no increment.
REQ-037 mie=0x800, MIE=1, irq_ext_i=1 -> irq_pending_o=1 one cycle later; trap_i and CSR write same cycle -> write dropped.

Source files
------------

// File: rtl/mcsr_pkg.sv
// mcsr_pkg: machine-mode CSR addresses, access op encodings and bit positions
package mcsr_pkg;
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old, logic [31:0] wd);
    return op == OP_RW ? wd : op == OP_RS ? (old | wd) : op == OP_RC ? (old & ~wd) : old;
  endfunction
endpackage

// File: rtl/mcsr_counter64.sv
// mcsr_counter64: 64-bit event counter with inhibit and independent half writes
module mcsr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        inh_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);
  // a write to either half suppresses the increment; the other half holds
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_o <= '0;
    else if (wr_lo_i) cnt_o[31:0] <= wdata_i;
    else if (wr_hi_i) cnt_o[63:32] <= wdata_i;
    else if (inc_i && !inh_i) cnt_o <= cnt_o + 64'd1;
endmodule

// File: rtl/mcsr_file.sv
// mcsr_file: RV32 machine-mode CSR file with trap/mret handling, counters and interrupt pending
module mcsr_file
  import mcsr_pkg::*;
#(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_req_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        instr_ret_i,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_val_i,
  input  logic        mret_i,
  input  logic        irq_sw_i,
  input  logic        irq_tim_i,
  input  logic        irq_ext_i,
  output logic [31:0] trap_vec_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending_o
);
  logic        mstatus_mie_q, mstatus_mpie_q;
  logic [2:0]  mie_q, mip_q;
  logic [1:0]  cinh_q;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle, minstret;
  logic [31:0] mstatus_rd, mie_rd, mip_rd, cinh_rd, rd, wval;
  logic        hit, wr;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign mie_rd     = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
  assign mip_rd     = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};
  assign cinh_rd    = {29'b0, cinh_q[1], 1'b0, cinh_q[0]};

  always_comb begin
    rd  = '0;
    hit = 1'b1;
    case (csr_addr_i)
      CSR_MISA:                              rd = MISA_VAL;
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rd = '0;
      CSR_MHARTID:                           rd = HART_ID;
      CSR_MSTATUS:                           rd = mstatus_rd;
      CSR_MIE:                               rd = mie_rd;
      CSR_MTVEC:                             rd = mtvec_q;
      CSR_MCOUNTINHIBIT:                     rd = cinh_rd;
      CSR_MSCRATCH:                          rd = mscratch_q;
      CSR_MEPC:                              rd = mepc_q;
      CSR_MCAUSE:                            rd = mcause_q;
      CSR_MTVAL:                             rd = mtval_q;
      CSR_MIP:                               rd = mip_rd;
      CSR_MCYCLE:                            rd = mcycle[31:0];
      CSR_MCYCLEH:                           rd = mcycle[63:32];
      CSR_MINSTRET:                          rd = minstret[31:0];
      CSR_MINSTRETH:                         rd = minstret[63:32];
      default:                               hit = 1'b0;
    endcase
  end

  assign csr_illegal_o = csr_req_i && (!hit || (csr_op_i != OP_NONE && csr_addr_i[11:10] == 2'b11));
  assign csr_rdata_o   = (csr_req_i && !csr_illegal_o) ? rd : '0;
  assign wval          = csr_apply(csr_op_e'(csr_op_i), rd, csr_wdata_i);
  // trap and mret own the cycle; a coincident CSR write is silently dropped
  assign wr            = csr_req_i && csr_op_i != OP_NONE && !csr_illegal_o && !trap_i && !mret_i;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      cinh_q         <= '0;
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else if (trap_i) begin
      mepc_q         <= trap_pc_i & ~32'd3;
      mcause_q       <= trap_cause_i;
      mtval_q        <= trap_val_i;
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (wr) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_mie_q  <= wval[MSTATUS_MIE];
          mstatus_mpie_q <= wval[MSTATUS_MPIE];
        end
        CSR_MIE:           mie_q      <= {wval[MIP_MEIP], wval[MIP_MTIP], wval[MIP_MSIP]};
        CSR_MTVEC:         mtvec_q    <= {wval[31:2], wval[1] ? mtvec_q[1:0] : wval[1:0]};
        CSR_MCOUNTINHIBIT: cinh_q     <= {wval[2], wval[0]};
        CSR_MSCRATCH:      mscratch_q <= wval;
        CSR_MEPC:          mepc_q     <= {wval[31:2], 2'b00};
        CSR_MCAUSE:        mcause_q   <= wval;
        CSR_MTVAL:         mtval_q    <= wval;
        default: ;
      endcase
    end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) mip_q <= '0;
    else mip_q <= {irq_ext_i, irq_tim_i, irq_sw_i};

  mcsr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .inh_i   (cinh_q[0]),
    .wr_lo_i (wr && csr_addr_i == CSR_MCYCLE),
    .wr_hi_i (wr && csr_addr_i == CSR_MCYCLEH),
    .wdata_i (wval),
    .cnt_o   (mcycle)
  );

  mcsr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (instr_ret_i),
    .inh_i   (cinh_q[1]),
    .wr_lo_i (wr && csr_addr_i == CSR_MINSTRET),
    .wr_hi_i (wr && csr_addr_i == CSR_MINSTRETH),
    .wdata_i (wval),
    .cnt_o   (minstret)
  );

  assign trap_vec_o    = {mtvec_q[31:2], 2'b00} +
                         ((mtvec_q[1:0] == 2'b01 && trap_cause_i[31]) ? {25'b0, trap_cause_i[4:0], 2'b00} : 32'd0);
  assign mepc_o        = mepc_q;
  assign irq_pending_o = mstatus_mie_q && |(mip_q & mie_q);
endmodule
